// File: rtl/dmem_responder_if.sv
// Request/response bus between the pipeline MEM/WB stages and the data-memory responder.
// The MEM/WB side uses the master modport; the responder uses the slave modport.
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_we;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_sel;
    logic        rsp_err;

    modport master (
        output req_valid, req_addr, req_wdata, req_we, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_sel, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, req_wdata, req_we, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_sel, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: lane-aligns one load/store, accesses a
// word RAM after a fixed latency and returns the raw word over a valid/ready handshake.
module dmem_responder #(
    parameter int ADDR_WIDTH = 12,
    parameter int LATENCY    = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    dmem_responder_if.slave    bus,
    input  logic               abort,
    output logic               busy
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    // Loaded with LATENCY so that rsp_valid rises LATENCY+1 edges after the accept edge.
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    function automatic logic [7:0] align_we(input logic [3:0] we, input logic [1:0] ofs);
        return {4'b0000, we} << ofs;
    endfunction

    function automatic logic [31:0] align_data(input logic [31:0] d, input logic [1:0] ofs);
        return d << {ofs, 3'b000};
    endfunction

    logic [31:0]           mem_r [DEPTH];

    state_t                state_r,     state_s;
    logic [3:0]            cnt_r,       cnt_s;
    logic [ADDR_WIDTH-1:0] idx_r,       idx_s;
    logic [1:0]            ofs_r,       ofs_s;
    logic [31:0]           wdata_r,     wdata_s;
    logic [3:0]            we_r,        we_s;
    logic                  store_r,     store_s;
    logic                  err_r,       err_s;
    logic                  rsp_valid_r, rsp_valid_s;
    logic [31:0]           rsp_rdata_r, rsp_rdata_s;
    logic [1:0]            rsp_sel_r,   rsp_sel_s;
    logic                  rsp_err_r,   rsp_err_s;
    logic                  busy_r,      busy_s;
    logic                  mem_wr_s;
    logic                  req_ready_s;
    logic [7:0]            req_we_al_s;

    assign req_ready_s   = (state_r == ST_IDLE) && !abort;
    assign req_we_al_s   = align_we(bus.req_we, bus.req_addr[1:0]);

    assign bus.req_ready = req_ready_s;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_rdata = rsp_rdata_r;
    assign bus.rsp_sel   = rsp_sel_r;
    assign bus.rsp_err   = rsp_err_r;
    assign busy          = busy_r;

    // Next-state and next-output logic for the IDLE/WAIT/RESP controller.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        idx_s       = idx_r;
        ofs_s       = ofs_r;
        wdata_s     = wdata_r;
        we_s        = we_r;
        store_s     = store_r;
        err_s       = err_r;
        rsp_valid_s = rsp_valid_r;
        rsp_rdata_s = rsp_rdata_r;
        rsp_sel_s   = rsp_sel_r;
        rsp_err_s   = rsp_err_r;
        busy_s      = busy_r;
        mem_wr_s    = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (bus.req_valid && req_ready_s) begin
                    state_s = ST_WAIT;
                    cnt_s   = CNT_LOAD;
                    idx_s   = bus.req_addr[ADDR_WIDTH+1:2];
                    ofs_s   = bus.req_addr[1:0];
                    wdata_s = align_data(bus.req_wdata, bus.req_addr[1:0]);
                    we_s    = req_we_al_s[3:0];
                    store_s = (bus.req_we != 4'b0000);
                    err_s   = (req_we_al_s[7:4] != 4'b0000) ||
                              (bus.req_addr[31:ADDR_WIDTH+2] != '0);
                    busy_s  = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                // A store is already committed architecturally, so abort only cancels loads.
                if (abort && !store_r) begin
                    state_s = ST_IDLE;
                    busy_s  = 1'b0;
                end else if (cnt_r == 4'd0) begin
                    state_s     = ST_RESP;
                    rsp_valid_s = 1'b1;
                    rsp_sel_s   = ofs_r;
                    rsp_err_s   = err_r;
                    mem_wr_s    = store_r && !err_r;
                    if (!store_r && !err_r) begin
                        rsp_rdata_s = mem_r[idx_r];
                    end else begin
                        rsp_rdata_s = 32'h0000_0000;
                    end
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready || abort) begin
                    state_s     = ST_IDLE;
                    rsp_valid_s = 1'b0;
                    busy_s      = 1'b0;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: begin
                state_s     = ST_IDLE;
                rsp_valid_s = 1'b0;
                busy_s      = 1'b0;
            end
        endcase
    end

    // Controller, request latch and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 4'd0;
            idx_r       <= '0;
            ofs_r       <= 2'b00;
            wdata_r     <= 32'h0000_0000;
            we_r        <= 4'b0000;
            store_r     <= 1'b0;
            err_r       <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 32'h0000_0000;
            rsp_sel_r   <= 2'b00;
            rsp_err_r   <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            idx_r       <= idx_s;
            ofs_r       <= ofs_s;
            wdata_r     <= wdata_s;
            we_r        <= we_s;
            store_r     <= store_s;
            err_r       <= err_s;
            rsp_valid_r <= rsp_valid_s;
            rsp_rdata_r <= rsp_rdata_s;
            rsp_sel_r   <= rsp_sel_s;
            rsp_err_r   <= rsp_err_s;
            busy_r      <= busy_s;
        end
    end

    // Byte-lane RAM write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_wr_s) begin
            for (int i = 0; i < 4; i++) begin
                if (we_r[i]) begin
                    mem_r[idx_r][8*i +: 8] <= wdata_r[8*i +: 8];
                end
            end
        end
    end
endmodule
